// File: rtl/pipeline_ctrl.sv
// Hazard and stall controller for a five-stage in-order pipeline.
// Produces Mealy stage-register enables and flushes; tracks halt drain and frozen-PC cycles.
module pipeline_ctrl #(
  parameter int STALL_CNT_W  = 16,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [3:0]             IF_ID_Rs,
  input  logic [3:0]             IF_ID_Rt,
  input  logic                   IF_ID_uses_Rt,
  input  logic                   ID_EX_MemRead,
  input  logic [3:0]             ID_EX_Rd,
  input  logic                   branch_taken,
  input  logic                   halt_ID,
  input  logic                   imem_ready,
  input  logic                   dmem_req,
  input  logic                   dmem_ready,
  output logic                   pc_write,
  output logic                   IF_ID_write,
  output logic                   ID_EX_write,
  output logic                   EX_MEM_write,
  output logic                   MEM_WB_write,
  output logic                   IF_ID_flush,
  output logic                   ID_EX_flush,
  output logic [1:0]             state,
  output logic                   done,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 2);
  localparam logic [DRAIN_W-1:0] DRAIN_MAX = DRAIN_W'(DRAIN_CYCLES);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LU_STALL = 2'b01,
    MEM_WAIT = 2'b10,
    HALTED   = 2'b11
  } state_t;

  state_t             cur;
  state_t             nxt;
  logic [DRAIN_W-1:0] drain_cnt;
  logic [DRAIN_W-1:0] drain_nxt;
  logic               mw;
  logic               lu;

  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
    return (&v) ? v : v + STALL_CNT_W'(1);
  endfunction

  function automatic logic [DRAIN_W-1:0] drain_inc(input logic [DRAIN_W-1:0] v);
    return (v >= DRAIN_MAX) ? v : v + DRAIN_W'(1);
  endfunction

  assign state = cur;
  assign mw    = dmem_req & ~dmem_ready;
  assign lu    = ID_EX_MemRead & (ID_EX_Rd != 4'd0) &
                 ((ID_EX_Rd == IF_ID_Rs) | (IF_ID_uses_Rt & (ID_EX_Rd == IF_ID_Rt)));

  always_comb begin
    pc_write     = 1'b1;
    IF_ID_write  = 1'b1;
    ID_EX_write  = 1'b1;
    EX_MEM_write = 1'b1;
    MEM_WB_write = 1'b1;
    IF_ID_flush  = 1'b0;
    ID_EX_flush  = 1'b0;
    nxt          = cur;
    drain_nxt    = drain_cnt;
    if (rst_n) begin
      case (cur)
        RUN, LU_STALL: begin
          nxt = RUN;
          // Order encodes priority: memory freeze, load-use bubble, halt, redirect, fetch miss.
          if (mw) begin
            pc_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_write  = 1'b0;
            EX_MEM_write = 1'b0;
            MEM_WB_write = 1'b0;
            nxt          = MEM_WAIT;
          end else if ((cur == RUN) && lu) begin
            pc_write    = 1'b0;
            IF_ID_write = 1'b0;
            ID_EX_flush = 1'b1;
            nxt         = LU_STALL;
          end else if (halt_ID) begin
            pc_write    = 1'b0;
            IF_ID_write = 1'b0;
            ID_EX_flush = 1'b1;
            drain_nxt   = '0;
            nxt         = HALTED;
          end else if (branch_taken) begin
            IF_ID_flush = 1'b1;
          end else if (!imem_ready) begin
            pc_write    = 1'b0;
            IF_ID_flush = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (dmem_ready) begin
            nxt = RUN;
          end else begin
            pc_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_write  = 1'b0;
            EX_MEM_write = 1'b0;
            MEM_WB_write = 1'b0;
          end
        end
        HALTED: begin
          pc_write    = 1'b0;
          IF_ID_write = 1'b0;
          ID_EX_flush = 1'b1;
          // Older instructions keep draining unless the memory stage is waiting.
          if (mw) begin
            ID_EX_write  = 1'b0;
            EX_MEM_write = 1'b0;
            MEM_WB_write = 1'b0;
          end else begin
            drain_nxt = drain_inc(drain_cnt);
          end
        end
        default: nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur          <= RUN;
      drain_cnt    <= '0;
      done         <= 1'b0;
      stall_cycles <= '0;
    end else begin
      cur       <= nxt;
      drain_cnt <= drain_nxt;
      if ((nxt == HALTED) && (drain_nxt >= DRAIN_MAX)) begin
        done <= 1'b1;
      end
      if (!pc_write && (cur != HALTED)) begin
        stall_cycles <= sat_inc(stall_cycles);
      end
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: per-cycle comparison against a behavioural model
// plus hand-computed spot checks on key scenarios.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  IF_ID_Rs, IF_ID_Rt, ID_EX_Rd;
  logic        IF_ID_uses_Rt, ID_EX_MemRead, branch_taken, halt_ID;
  logic        imem_ready, dmem_req, dmem_ready;
  logic        pc_write, IF_ID_write, ID_EX_write, EX_MEM_write, MEM_WB_write;
  logic        IF_ID_flush, ID_EX_flush, done;
  logic [1:0]  state;
  logic [15:0] stall_cycles;
  logic        s_pc, s_ifw, s_idw, s_exw, s_mww, s_iff, s_idf, s_done;
  logic [1:0]  s_state;
  logic [2:0]  s_stall;

  wire [6:0] ctl   = {pc_write, IF_ID_write, ID_EX_write, EX_MEM_write, MEM_WB_write, IF_ID_flush, ID_EX_flush};
  wire [6:0] s_ctl = {s_pc, s_ifw, s_idw, s_exw, s_mww, s_iff, s_idf};

  always #5 clk = ~clk;

  pipeline_ctrl dut (
    .clk(clk), .rst_n(rst_n), .IF_ID_Rs(IF_ID_Rs), .IF_ID_Rt(IF_ID_Rt),
    .IF_ID_uses_Rt(IF_ID_uses_Rt), .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_Rd(ID_EX_Rd),
    .branch_taken(branch_taken), .halt_ID(halt_ID), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .pc_write(pc_write),
    .IF_ID_write(IF_ID_write), .ID_EX_write(ID_EX_write), .EX_MEM_write(EX_MEM_write),
    .MEM_WB_write(MEM_WB_write), .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush),
    .state(state), .done(done), .stall_cycles(stall_cycles)
  );

  pipeline_ctrl #(.STALL_CNT_W(3)) u_sat (
    .clk(clk), .rst_n(rst_n), .IF_ID_Rs(IF_ID_Rs), .IF_ID_Rt(IF_ID_Rt),
    .IF_ID_uses_Rt(IF_ID_uses_Rt), .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_Rd(ID_EX_Rd),
    .branch_taken(branch_taken), .halt_ID(halt_ID), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .pc_write(s_pc),
    .IF_ID_write(s_ifw), .ID_EX_write(s_idw), .EX_MEM_write(s_exw),
    .MEM_WB_write(s_mww), .IF_ID_flush(s_iff), .ID_EX_flush(s_idf),
    .state(s_state), .done(s_done), .stall_cycles(s_stall)
  );

  // Model: each cycle is classified into one pipeline action, which fixes outputs and next state.
  localparam int A_ADV = 0, A_FREEZE = 1, A_LU = 2, A_HALTIN = 3, A_REDIR = 4,
                 A_MISS = 5, A_DRAIN = 6, A_HOLD = 7, A_RESET = 8;
  localparam int S_RUN = 0, S_LU = 1, S_MW = 2, S_HLT = 3;
  localparam int DRAIN = 3;

  int n_vec = 0;
  int n_err = 0;
  int m_st, m_drain, m_stall, n_st, n_drain, n_stall;
  bit m_done, n_done;
  bit m_valid = 1'b0;

  function automatic logic [6:0] action_ctl(input int act);
    case (act)
      A_FREEZE: return 7'b0000000;
      A_LU:     return 7'b0011101;
      A_HALTIN: return 7'b0011101;
      A_REDIR:  return 7'b1111110;
      A_MISS:   return 7'b0111110;
      A_DRAIN:  return 7'b0011101;
      A_HOLD:   return 7'b0000001;
      default:  return 7'b1111100;
    endcase
  endfunction

  task automatic model_check();
    int act;
    logic [6:0] exp_ctl;
    bit mwv, luv;
    mwv = dmem_req && !dmem_ready;
    luv = ID_EX_MemRead && (ID_EX_Rd != 0) &&
          ((ID_EX_Rd == IF_ID_Rs) || (IF_ID_uses_Rt && (ID_EX_Rd == IF_ID_Rt)));
    if (!rst_n)              act = A_RESET;
    else if (m_st == S_MW)   act = dmem_ready ? A_ADV : A_FREEZE;
    else if (m_st == S_HLT)  act = mwv ? A_HOLD : A_DRAIN;
    else if (mwv)            act = A_FREEZE;
    else if (luv && m_st == S_RUN) act = A_LU;
    else if (halt_ID)        act = A_HALTIN;
    else if (branch_taken)   act = A_REDIR;
    else if (!imem_ready)    act = A_MISS;
    else                     act = A_ADV;
    exp_ctl = action_ctl(act);
    case (act)
      A_FREEZE:                 n_st = S_MW;
      A_LU:                     n_st = S_LU;
      A_HALTIN, A_DRAIN, A_HOLD: n_st = S_HLT;
      default:                  n_st = S_RUN;
    endcase
    n_drain = (act == A_HALTIN) ? 0 : (act == A_DRAIN) ? ((m_drain + 1 > DRAIN) ? DRAIN : m_drain + 1) : m_drain;
    n_done  = m_done || (n_st == S_HLT && n_drain >= DRAIN);
    n_stall = (!exp_ctl[6] && m_st != S_HLT && m_stall < 65535) ? m_stall + 1 : m_stall;
    if (m_valid) begin
      n_vec++;
      if (ctl !== exp_ctl || state !== 2'(m_st) || done !== m_done || stall_cycles !== 16'(m_stall)) begin
        n_err++;
        $display("FAIL cycle@%0t: ctl=%b state=%0d done=%0b stall=%0d, model ctl=%b state=%0d done=%0b stall=%0d",
                 $time, ctl, state, done, stall_cycles, exp_ctl, m_st, m_done, m_stall);
      end
    end
  endtask

  task automatic model_commit();
    if (!rst_n) begin
      m_st = S_RUN; m_drain = 0; m_done = 1'b0; m_stall = 0; m_valid = 1'b1;
    end else if (m_valid) begin
      m_st = n_st; m_drain = n_drain; m_done = n_done; m_stall = n_stall;
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      model_check();
      @(posedge clk);
      model_commit();
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, wanted %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    IF_ID_Rs = 4'd0; IF_ID_Rt = 4'd0; IF_ID_uses_Rt = 1'b0; ID_EX_MemRead = 1'b0;
    ID_EX_Rd = 4'd0; branch_taken = 1'b0; halt_ID = 1'b0; imem_ready = 1'b1;
    dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic set_lu(input logic [3:0] r);
    ID_EX_MemRead = 1'b1; ID_EX_Rd = r; IF_ID_Rs = r;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    step(2);
    chk("reset_ctl", 32'(ctl), 32'b1111100);
    chk("reset_state", 32'(state), 0);
    chk("reset_stall", 32'(stall_cycles), 0);
    rst_n = 1'b1;
    step(2);

    // load-use bubble, lu held into LU_STALL must be ignored
    set_lu(4'd5); #1;
    chk("lu_pc", 32'(pc_write), 0);
    chk("lu_idex_flush", 32'(ID_EX_flush), 1);
    step();
    chk("lu_state", 32'(state), 1);
    chk("lu_stall_pc", 32'(pc_write), 1);
    step();
    chk("lu_back_run", 32'(state), 0);
    chk("lu_stall_cnt", 32'(stall_cycles), 1);
    idle();

    // load to $0 never stalls
    set_lu(4'd0); #1;
    chk("zero_pc", 32'(pc_write), 1);
    step();
    chk("zero_state", 32'(state), 0);
    idle();

    // Rt dependency only counts when Rt is read
    ID_EX_MemRead = 1'b1; ID_EX_Rd = 4'd7; IF_ID_Rs = 4'd3; IF_ID_Rt = 4'd7;
    step();
    IF_ID_uses_Rt = 1'b1; #1;
    chk("rt_pc", 32'(pc_write), 0);
    step(2);
    idle();

    // load-use with branch: bubble first, flush next cycle
    set_lu(4'd4); branch_taken = 1'b1; #1;
    chk("lubr_ifid_flush", 32'(IF_ID_flush), 0);
    step();
    chk("lubr_state", 32'(state), 1);
    chk("lubr_ctl", 32'(ctl), 32'b1111110);
    step();
    idle();

    // fetch miss, then redirect during miss
    imem_ready = 1'b0; #1;
    chk("miss_ctl", 32'(ctl), 32'b0111110);
    step();
    branch_taken = 1'b1; #1;
    chk("miss_redirect_pc", 32'(pc_write), 1);
    step();
    idle();
    chk("stall_before_mw", 32'(stall_cycles), 4);

    // memory wait with lu present: memory freeze wins
    set_lu(4'd6); dmem_req = 1'b1; #1;
    chk("mw_ctl", 32'(ctl), 0);
    step();
    chk("mw_state", 32'(state), 2);
    ID_EX_MemRead = 1'b0;
    step(4);
    dmem_ready = 1'b1; #1;
    chk("mw_release_ctl", 32'(ctl), 32'b1111100);
    step();
    chk("mw_run", 32'(state), 0);
    chk("mw_stall_cnt", 32'(stall_cycles), 9);
    idle();

    // memory wait entered from LU_STALL
    set_lu(4'd2);
    step();
    dmem_req = 1'b1; #1;
    chk("lumw_ctl", 32'(ctl), 0);
    step();
    chk("lumw_state", 32'(state), 2);
    dmem_ready = 1'b1;
    step();
    idle();
    chk("lumw_stall_cnt", 32'(stall_cycles), 11);

    // reset mid MEM_WAIT
    dmem_req = 1'b1;
    step(2);
    rst_n = 1'b0; #1;
    chk("rst_mw_ctl", 32'(ctl), 32'b1111100);
    step();
    rst_n = 1'b1; idle(); #1;
    chk("rst_mw_state", 32'(state), 0);
    chk("rst_mw_stall", 32'(stall_cycles), 0);
    chk("rst_mw_ctl_after", 32'(ctl), 32'b1111100);

    // halt with three advancing cycles
    halt_ID = 1'b1; #1;
    chk("halt_pc", 32'(pc_write), 0);
    step();
    halt_ID = 1'b0; imem_ready = 1'b0;
    chk("halt_state", 32'(state), 3);
    step(2);
    chk("halt_done_early", 32'(done), 0);
    step();
    chk("halt_done", 32'(done), 1);
    chk("halt_stall_cnt", 32'(stall_cycles), 1);
    step(2);

    // halt with a two-cycle memory wait inserted
    rst_n = 1'b0; idle();
    step();
    rst_n = 1'b1; halt_ID = 1'b1;
    step();
    halt_ID = 1'b0;
    step();
    dmem_req = 1'b1; #1;
    chk("halt_mw_ctl", 32'(ctl), 32'b0000001);
    step(2);
    dmem_req = 1'b0;
    step();
    chk("halt_mw_done_early", 32'(done), 0);
    step();
    chk("halt_mw_done", 32'(done), 1);

    // stall counter saturation on the narrow instance
    rst_n = 1'b0; idle();
    step();
    rst_n = 1'b1; imem_ready = 1'b0;
    step(7);
    chk("sat_7", 32'(s_stall), 7);
    step(3);
    chk("sat_hold", 32'(s_stall), 7);
    chk("sat_ctl", 32'(s_ctl), 32'b0111110);
    chk("sat_state_done", 32'({s_state, s_done}), 0);
    chk("wide_stall", 32'(stall_cycles), 10);
    idle();
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
